// File: rtl/implication_monitor_if.sv
// implication_monitor_if: observed producer/register pair and check results.
// Carries pass_count only when IMPLICATION_MONITOR_COVER_EN is defined.
interface implication_monitor_if #(
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
);
  logic             en;
  logic             clr;
  logic             antecedent;
  logic             consequent;
  logic             fail;
  logic             fail_sticky;
  logic [CNT_W-1:0] fail_count;
  logic [TS_W-1:0]  first_fail_ts;
  logic             pending;
  logic [1:0]       state;
`ifdef IMPLICATION_MONITOR_COVER_EN
  logic [CNT_W-1:0] pass_count;

  modport master (
    output en, clr, antecedent, consequent,
    input  fail, fail_sticky, fail_count,
    input  first_fail_ts, pending, state,
    input  pass_count
  );

  modport slave (
    input  en, clr, antecedent, consequent,
    output fail, fail_sticky, fail_count,
    output first_fail_ts, pending, state,
    output pass_count
  );
`else
  modport master (
    output en, clr, antecedent, consequent,
    input  fail, fail_sticky, fail_count,
    input  first_fail_ts, pending, state
  );

  modport slave (
    input  en, clr, antecedent, consequent,
    output fail, fail_sticky, fail_count,
    output first_fail_ts, pending, state
  );
`endif
endinterface

// File: rtl/implication_monitor.sv
// implication_monitor: run-time checker for "antecedent |-> ##DELAY consequent".
// Define IMPLICATION_MONITOR_COVER_EN to add the saturating pass_count output.
module implication_monitor #(
  parameter int DELAY = 1,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  implication_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    FAILED = 2'd2
  } state_e;

  state_e           st_q, st_d;
  logic [DELAY-1:0] p_q, p_d;
  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  first_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fail_q;
  logic             sticky_q;
  logic             due;
  logic             miss;

  assign due  = p_q[DELAY-1];
  // clr discards the outcome of a check landing in the same cycle
  assign miss = due & ~mon.consequent & ~mon.clr;

  always_comb begin
    p_d = '0;
    if (!mon.clr) begin
      p_d    = p_q << 1;
      p_d[0] = mon.antecedent & mon.en;
    end
  end

  always_comb begin
    st_d = st_q;
    if (mon.clr) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        IDLE: begin
          if (miss)      st_d = FAILED;
          else if (|p_d) st_d = ARMED;
        end
        ARMED: begin
          if (miss)       st_d = FAILED;
          else if (!(|p_d)) st_d = IDLE;
        end
        FAILED:  st_d = FAILED;
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      st_q <= IDLE;
      p_q  <= '0;
    end else begin
      st_q <= st_d;
      p_q  <= p_d;
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      ts_q     <= '0;
      first_q  <= '0;
      cnt_q    <= '0;
      fail_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else if (mon.clr) begin
      ts_q     <= '0;
      first_q  <= '0;
      cnt_q    <= '0;
      fail_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (ts_q != '1) ts_q <= ts_q + 1'b1;
      fail_q <= miss;
      if (miss) begin
        sticky_q <= 1'b1;
        if (!sticky_q) first_q <= ts_q;
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef IMPLICATION_MONITOR_COVER_EN
  logic             hit;
  logic [CNT_W-1:0] pass_q;

  assign hit = due & mon.consequent & ~mon.clr;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET)            pass_q <= '0;
    else if (mon.clr)          pass_q <= '0;
    else if (hit && pass_q != '1) pass_q <= pass_q + 1'b1;
  end

  assign mon.pass_count = pass_q;
`endif

  assign mon.fail          = fail_q;
  assign mon.fail_sticky   = sticky_q;
  assign mon.fail_count    = cnt_q;
  assign mon.first_fail_ts = first_q;
  assign mon.pending       = |p_q;
  assign mon.state         = st_q;

endmodule

// File: tb/tb_implication_monitor.sv
// tb_implication_monitor: three monitors (DELAY 1/3/2) on shared stimulus,
// checked every cycle against a cycle-history model plus literal expectations.
module tb_implication_monitor;

  logic CLK = 1'b0;
  logic ASYNCRESET = 1'b1;
  logic en = 1'b0, clr = 1'b0, ant = 1'b0, cons = 1'b0;

  always #5 CLK = ~CLK;

  implication_monitor_if #(.CNT_W(8), .TS_W(16)) if0 ();
  implication_monitor_if #(.CNT_W(8), .TS_W(16)) if1 ();
  implication_monitor_if #(.CNT_W(2), .TS_W(16)) if2 ();

  assign if0.en = en; assign if0.clr = clr;
  assign if0.antecedent = ant; assign if0.consequent = cons;
  assign if1.en = en; assign if1.clr = clr;
  assign if1.antecedent = ant; assign if1.consequent = cons;
  assign if2.en = en; assign if2.clr = clr;
  assign if2.antecedent = ant; assign if2.consequent = cons;

  implication_monitor #(.DELAY(1), .CNT_W(8), .TS_W(16)) u0 (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .mon(if0));
  implication_monitor #(.DELAY(3), .CNT_W(8), .TS_W(16)) u1 (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .mon(if1));
  implication_monitor #(.DELAY(2), .CNT_W(2), .TS_W(16)) u2 (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .mon(if2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: remembers per cycle whether an obligation was captured and
  // whether clr was high; an obligation survives until a later clr.
  int D [3]    = '{1, 3, 2};
  int CMAX [3] = '{255, 255, 3};
  bit cap [4096];
  bit clrh [4096];
  int cyc = 0;
  int start = 0;
  int m_ts = 0;
  bit e_fail [3], e_stk [3], e_pend [3];
  int e_cnt [3], e_first [3], e_pass [3];

  function automatic bit alive(int s, int t);
    if (s < start || s < 0) return 1'b0;
    if (!cap[s]) return 1'b0;
    for (int c = s + 1; c <= t; c++)
      if (clrh[c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    start = cyc;
    m_ts  = 0;
    for (int k = 0; k < 3; k++) begin
      e_fail[k] = 0; e_stk[k] = 0; e_pend[k] = 0;
      e_cnt[k] = 0; e_first[k] = 0; e_pass[k] = 0;
    end
  endtask

  task automatic model_step();
    int t;
    bit due;
    t = cyc;
    cap[t]  = ant & en & ~clr;
    clrh[t] = clr;
    for (int k = 0; k < 3; k++) begin
      due = (t - D[k] >= 0) && alive(t - D[k], t - 1);
      if (clr) begin
        e_fail[k] = 0; e_stk[k] = 0;
        e_cnt[k] = 0; e_first[k] = 0; e_pass[k] = 0;
      end else begin
        e_fail[k] = due && !cons;
        if (e_fail[k]) begin
          if (!e_stk[k]) e_first[k] = m_ts;
          e_stk[k] = 1;
          if (e_cnt[k] < CMAX[k]) e_cnt[k]++;
        end
        if (due && cons && e_pass[k] < CMAX[k]) e_pass[k]++;
      end
      e_pend[k] = 0;
      for (int s = t - D[k] + 1; s <= t; s++)
        if (alive(s, t)) e_pend[k] = 1;
    end
    m_ts = clr ? 0 : (m_ts < 65535 ? m_ts + 1 : m_ts);
    cyc++;
  endtask

  task automatic cmp(input int k, input logic f, input logic stk,
                     input logic [31:0] cnt, input logic [31:0] first,
                     input logic pend, input logic [1:0] st,
                     input logic [31:0] pc);
    logic [1:0] est;
    est = e_stk[k] ? 2'd2 : (e_pend[k] ? 2'd1 : 2'd0);
    chk($sformatf("u%0d.fail@%0d", k, cyc), {31'd0, f}, {31'd0, e_fail[k]});
    chk($sformatf("u%0d.sticky@%0d", k, cyc), {31'd0, stk}, {31'd0, e_stk[k]});
    chk($sformatf("u%0d.count@%0d", k, cyc), cnt, e_cnt[k]);
    chk($sformatf("u%0d.first_ts@%0d", k, cyc), first, e_first[k]);
    chk($sformatf("u%0d.pending@%0d", k, cyc), {31'd0, pend}, {31'd0, e_pend[k]});
    chk($sformatf("u%0d.state@%0d", k, cyc), {30'd0, st}, {30'd0, est});
`ifdef IMPLICATION_MONITOR_COVER_EN
    chk($sformatf("u%0d.pass@%0d", k, cyc), pc, e_pass[k]);
`else
    if (pc !== 32'd0) chk("pc_tie", pc, 32'd0);
`endif
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge CLK or posedge ASYNCRESET);
      if (ASYNCRESET) begin
        model_reset();
      end else begin
`ifdef IMPLICATION_MONITOR_COVER_EN
        cmp(0, if0.fail, if0.fail_sticky, 32'(if0.fail_count),
            32'(if0.first_fail_ts), if0.pending, if0.state, 32'(if0.pass_count));
        cmp(1, if1.fail, if1.fail_sticky, 32'(if1.fail_count),
            32'(if1.first_fail_ts), if1.pending, if1.state, 32'(if1.pass_count));
        cmp(2, if2.fail, if2.fail_sticky, 32'(if2.fail_count),
            32'(if2.first_fail_ts), if2.pending, if2.state, 32'(if2.pass_count));
`else
        cmp(0, if0.fail, if0.fail_sticky, 32'(if0.fail_count),
            32'(if0.first_fail_ts), if0.pending, if0.state, 32'd0);
        cmp(1, if1.fail, if1.fail_sticky, 32'(if1.fail_count),
            32'(if1.first_fail_ts), if1.pending, if1.state, 32'd0);
        cmp(2, if2.fail, if2.fail_sticky, 32'(if2.fail_count),
            32'(if2.first_fail_ts), if2.pending, if2.state, 32'd0);
`endif
        model_step();
      end
    end
  end

  task automatic step(input logic a, input logic c, input logic e,
                      input logic r);
    ant = a; cons = c; en = e; clr = r;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1 ASYNCRESET = 1'b0;
    chk("reset.state", {30'd0, if1.state}, 32'd0);
    chk("reset.count", 32'(if1.fail_count), 32'd0);

    // single pass, DELAY=1
    step(0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step(i == 5, i == 6, 1, 0);
      if (i == 4) chk("A.pend_c5", {31'd0, if0.pending}, 32'd0);
      if (i == 5) chk("A.pend_c6", {31'd0, if0.pending}, 32'd1);
      if (i == 6) begin
        chk("A.pend_c7", {31'd0, if0.pending}, 32'd0);
        chk("A.state_c7", {30'd0, if0.state}, 32'd0);
        chk("A.fail_c7", {31'd0, if0.fail}, 32'd0);
        chk("A.count_c7", 32'(if0.fail_count), 32'd0);
`ifdef IMPLICATION_MONITOR_COVER_EN
        chk("A.pass_c7", 32'(if0.pass_count), 32'd1);
`endif
      end
    end

    // single fail, DELAY=3
    step(0, 0, 1, 1);
    for (int i = 0; i < 17; i++) begin
      step(i == 10, 0, 1, 0);
      if (i == 12) chk("B.fail_c13", {31'd0, if1.fail}, 32'd0);
      if (i == 13) chk("B.fail_c14", {31'd0, if1.fail}, 32'd1);
      if (i == 14) chk("B.fail_c15", {31'd0, if1.fail}, 32'd0);
    end
    chk("B.count", 32'(if1.fail_count), 32'd1);
    chk("B.sticky", {31'd0, if1.fail_sticky}, 32'd1);
    chk("B.first_ts", 32'(if1.first_fail_ts), 32'd13);
    chk("B.state", {30'd0, if1.state}, 32'd2);

    // overlap and saturation, DELAY=2 CNT_W=2
    step(0, 0, 1, 1);
    for (int i = 0; i < 11; i++) begin
      step(i <= 5, 0, 1, 0);
      if (i == 1) chk("C.fail_c2", {31'd0, if2.fail}, 32'd0);
      if (i == 2) chk("C.fail_c3", {31'd0, if2.fail}, 32'd1);
      if (i == 7) chk("C.fail_c8", {31'd0, if2.fail}, 32'd1);
      if (i == 8) chk("C.fail_c9", {31'd0, if2.fail}, 32'd0);
    end
    chk("C.count_sat", 32'(if2.fail_count), 32'd3);
    chk("C.first_ts", 32'(if2.first_fail_ts), 32'd2);

    // enable gating
    step(0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, i == 0, 0);
      if (i == 2) chk("D.fail_c3", {31'd0, if2.fail}, 32'd1);
      if (i == 3) chk("D.fail_c4", {31'd0, if2.fail}, 32'd0);
    end
    chk("D.count", 32'(if2.fail_count), 32'd1);

    // clr collides with a failing check on u2
    step(0, 0, 1, 1);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("E.fail", {31'd0, if2.fail}, 32'd0);
    chk("E.count", 32'(if2.fail_count), 32'd0);
    chk("E.sticky", {31'd0, if2.fail_sticky}, 32'd0);
    chk("E.state", {30'd0, if2.state}, 32'd0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("E.refail", {31'd0, if2.fail}, 32'd1);
    chk("E.ts_restart", 32'(if2.first_fail_ts), 32'd2);

    // async reset with obligations in flight
    step(1, 0, 1, 0);
    chk("F.pend_before", {31'd0, if2.pending}, 32'd1);
    ant = 1'b0;
    #2 ASYNCRESET = 1'b1;
    #1;
    chk("F.pend", {31'd0, if2.pending}, 32'd0);
    chk("F.sticky", {31'd0, if2.fail_sticky}, 32'd0);
    chk("F.count", 32'(if2.fail_count), 32'd0);
    chk("F.state", {30'd0, if2.state}, 32'd0);
    chk("F.u1_pend", {31'd0, if1.pending}, 32'd0);
    chk("F.u1_first", 32'(if1.first_fail_ts), 32'd0);
    ASYNCRESET = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    chk("F.u1_nofail", 32'(if1.fail_count), 32'd0);
    chk("F.u2_nofail", 32'(if2.fail_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/implication_monitor.md
Name: implication_monitor

Overview:
- Synthesizable run-time checker for the bounded implication "antecedent |-> ##DELAY consequent".
- It is the hardware-side counterpart of the simulation-only inline assertions emitted into generated designs. It observes a producer/register pair and reports obligation failures as flags and counters.
- It is instantiated alongside generated modules and is readable by debug logic when SVA is unavailable, such as on FPGA or in emulation.

Parameters:
- DELAY, 1, cycles between antecedent sample and consequent check; legal range 1..16.
- CNT_W, 8, width of the saturating failure counter.
- TS_W, 16, width of the free-running cycle timestamp.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- en  input  1  when high, antecedent is sampled into the obligation pipe.
- clr  input  1  synchronous clear of pipe, sticky flag, counters and timestamp capture.
- antecedent  input  1  trigger condition.
- consequent  input  1  expected condition DELAY cycles after the trigger.
- fail  output  1  one-cycle pulse per failed obligation.
- fail_sticky  output  1  set on first failure; held until clr or reset.
- fail_count  output  CNT_W  number of failures, saturating.
- first_fail_ts  output  TS_W  timestamp of the check cycle of the first failure.
- pending  output  1  at least one obligation in flight.
- state  output  2  0=IDLE, 1=ARMED, 2=FAILED.

Behaviour:
- **Reset.** ASYNCRESET high clears all outputs and internals immediately, independent of CLK: pipe, fail, fail_sticky, fail_count, first_fail_ts, ts and state=IDLE. Reset mid-obligation drops every in-flight obligation; no fail is produced for them.
- **Timestamp.** Internal ts increments every cycle and saturates at all-ones. clr resets ts to 0.
- **Obligation pipe.** Shift register p[DELAY-1:0]. Each cycle, p[0] <= antecedent & en, and p[i] <= p[i-1].
- **Check.** A check is due in cycle t when p[DELAY-1]=1, i.e. the antecedent was sampled with en at t-DELAY.
  - If consequent=0 in cycle t, then in cycle t+1: fail=1, fail_sticky=1, fail_count += 1 (saturating at 2^CNT_W-1).
  - If fail_sticky was 0, first_fail_ts <= ts value of cycle t.
  - Failure latency is exactly DELAY+1 clocks from the antecedent edge to the fail pulse.
- **Overlapping obligations.** These are independent. Back-to-back antecedents each get their own check, so consecutive failures produce consecutive fail pulses.
- **Enable.** en=0 blocks new obligations only. Obligations already in the pipe are still checked.
- **Clear.** clr=1 zeroes the pipe, fail, fail_sticky, fail_count, first_fail_ts and ts at the next edge, and forces state=IDLE.
  - clr wins over a simultaneous failure: that failure is discarded and not counted.
  - The antecedent in the clr cycle is not captured.
- **pending.** pending = |p, combinational from registers.
- **State machine.**
  - IDLE -> ARMED when an obligation enters the pipe.
  - ARMED -> IDLE when the pipe is empty and there is no failure.
  - IDLE/ARMED -> FAILED on the first failure.
  - FAILED is held until clr or reset.
  - Obligations continue to be tracked and counted while in FAILED.
- **Vacuous pass.** A consequent without a preceding antecedent has no effect.

Optional Feature:
- Macro: IMPLICATION_MONITOR_COVER_EN.
- **Defined.** Adds output pass_count (CNT_W, saturating). It increments in cycle t+1 for each due check with consequent=1, resets on ASYNCRESET and clr, and is discarded on the clr cycle in the same way as failures.
- **Undefined.** The port and its logic are absent; all other behaviour is identical.

Test Plan:
- **Single pass.** DELAY=1; antecedent=1 at cycle 5, consequent=1 at cycle 6 -> fail stays 0, pending=1 only during cycle 6, state returns to IDLE, fail_count=0 (pass_count=1 if cover enabled).
- **Single fail.** DELAY=3; antecedent at cycle 10 (ts=10), consequent=0 throughout -> fail pulses at cycle 14 only, fail_sticky=1, fail_count=1, first_fail_ts=13, state=FAILED.
- **Overlap and saturation.** DELAY=2, CNT_W=2; antecedent high for cycles 0..5, consequent low -> fail high for cycles 3..8, fail_count saturates at 3, first_fail_ts=2.
- **Enable gating.** en=0 at cycle 1 after an antecedent captured at cycle 0 with DELAY=2; consequent=0 -> one failure at cycle 3. Antecedents while en=0 produce no failures.
- **Clear collision.** clr=1 in the same cycle a check fails -> fail=0 next cycle, fail_count=0, fail_sticky=0, state=IDLE, ts restarts at 0.
- **Async reset mid-flight.** ASYNCRESET pulsed between clock edges while pending=1 -> all outputs 0 immediately, and no fail occurs afterwards for the dropped obligations.
